// File: rtl/core_pkg.sv
// Shared encodings for the instruction-decode stage: opcodes, immediate
// formats, funct7 values and the decoded-field bundle carried down the pipe.
package core_pkg;

   typedef enum logic [6:0] {
      OPC_LOAD   = 7'b0000011,
      OPC_FENCE  = 7'b0001111,
      OPC_ALI    = 7'b0010011,
      OPC_AUIPC  = 7'b0010111,
      OPC_STORE  = 7'b0100011,
      OPC_ALR    = 7'b0110011,
      OPC_LUI    = 7'b0110111,
      OPC_BRANCH = 7'b1100011,
      OPC_JALR   = 7'b1100111,
      OPC_JAL    = 7'b1101111,
      OPC_SYSTEM = 7'b1110011
   } opcode_e;

   typedef enum logic [2:0] {
      IT_UNKNOWN,
      IT_R,
      IT_I,
      IT_IZ,
      IT_S,
      IT_B,
      IT_U,
      IT_J
   } itype_e;

   typedef enum logic [6:0] {
      F7_BASE   = 7'b0000000,
      F7_MULDIV = 7'b0000001,
      F7_ALT    = 7'b0100000
   } funct7_e;

   typedef struct packed {
      logic [6:0] opcode;
      logic [2:0] funct3;
      logic [6:0] funct7;
      logic [4:0] src1_addr;
      logic [4:0] src2_addr;
      logic [4:0] dst_addr;
      logic       src1_en;
      logic       src2_en;
      logic       dst_en;
      logic       jal;
      logic       jalr;
      logic       branch;
      logic       alures2reg;
      logic       memory2reg;
      logic       mem_write;
      logic       muldiv;
      logic       csr;
      logic       illegal;
   } dec_t;

endpackage

// File: rtl/core_id_decode.sv
// Combinational RV32I decoder with optional M and Zicsr; produces the raw
// fields, enables, class flags, illegal flag and the XLEN-wide immediate.
module core_id_decode
   import core_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter bit ENABLE_M   = 1'b1,
   parameter bit ENABLE_CSR = 1'b1
) (
   input  logic [31:0]     i_instr,
   output dec_t            o_dec,
   output logic [XLEN-1:0] o_imm
);

   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [6:0]  sh_f7;
   logic [31:0] imm32;
   itype_e      itype;
   logic        ill;

   always_comb begin
      opc   = i_instr[6:0];
      f3    = i_instr[14:12];
      f7    = i_instr[31:25];
      // on RV64 shamt[5] lives in bit 25, so only bits 31:26 must match funct7
      sh_f7 = (XLEN == 64) ? {i_instr[31:26], 1'b0} : i_instr[31:25];
      itype = IT_UNKNOWN;
      ill   = 1'b0;
      o_dec = '0;
      o_dec.opcode    = opc;
      o_dec.funct3    = f3;
      o_dec.funct7    = f7;
      o_dec.src1_addr = i_instr[19:15];
      o_dec.src2_addr = i_instr[24:20];
      o_dec.dst_addr  = i_instr[11:7];

      case (opc)
         OPC_LUI, OPC_AUIPC: begin
            itype = IT_U;
            o_dec.alures2reg = 1'b1;
         end
         OPC_JAL: begin
            itype = IT_J;
            o_dec.jal        = 1'b1;
            o_dec.alures2reg = 1'b1;
         end
         OPC_JALR: begin
            itype = IT_I;
            o_dec.jalr       = 1'b1;
            o_dec.alures2reg = 1'b1;
            ill = (f3 != 3'b000);
         end
         OPC_BRANCH: begin
            itype = IT_B;
            o_dec.branch = 1'b1;
            ill = (f3[2:1] == 2'b01);
         end
         OPC_LOAD: begin
            itype = IT_I;
            o_dec.memory2reg = 1'b1;
            ill = (f3 == 3'b011) || (f3[2:1] == 2'b11);
         end
         OPC_STORE: begin
            itype = IT_S;
            o_dec.mem_write = 1'b1;
            ill = (f3 > 3'b010);
         end
         OPC_ALI: begin
            itype = IT_I;
            o_dec.alures2reg = 1'b1;
            if (f3 == 3'b001)
               ill = (sh_f7 != F7_BASE);
            else if (f3 == 3'b101)
               ill = (sh_f7 != F7_BASE) && (sh_f7 != F7_ALT);
         end
         OPC_ALR: begin
            itype = IT_R;
            o_dec.alures2reg = 1'b1;
            if (f7 == F7_MULDIV) begin
               o_dec.muldiv = ENABLE_M;
               ill = !ENABLE_M;
            end else begin
               ill = (f7 != F7_BASE) && (f7 != F7_ALT);
            end
         end
         OPC_FENCE: ;
         OPC_SYSTEM: begin
            if (f3 == 3'b000 || !ENABLE_CSR) begin
               ill = 1'b1;
            end else begin
               itype = IT_IZ;
               o_dec.csr        = 1'b1;
               o_dec.alures2reg = 1'b1;
            end
         end
         default: ill = 1'b1;
      endcase

      o_dec.src1_en = itype inside {IT_R, IT_I, IT_S, IT_B};
      o_dec.src2_en = itype inside {IT_R, IT_S, IT_B};
      o_dec.dst_en  = (itype inside {IT_R, IT_I, IT_U, IT_J, IT_IZ}) && (i_instr[11:7] != 5'd0);
      if (itype == IT_IZ)
         o_dec.src1_en = !f3[2];

      if (ill) begin
         o_dec.src1_en    = 1'b0;
         o_dec.src2_en    = 1'b0;
         o_dec.dst_en     = 1'b0;
         o_dec.jal        = 1'b0;
         o_dec.jalr       = 1'b0;
         o_dec.branch     = 1'b0;
         o_dec.alures2reg = 1'b0;
         o_dec.memory2reg = 1'b0;
         o_dec.mem_write  = 1'b0;
         o_dec.muldiv     = 1'b0;
         o_dec.csr        = 1'b0;
      end
      o_dec.illegal = ill;
   end

   always_comb begin
      case (itype)
         IT_I:    imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
         IT_IZ:   imm32 = {20'd0, i_instr[31:20]};
         IT_S:    imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
         IT_B:    imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
         IT_U:    imm32 = {i_instr[31:12], 12'd0};
         IT_J:    imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
         default: imm32 = '0;
      endcase
      o_imm = XLEN'($signed(imm32));
   end

endmodule

// File: rtl/core_id_pipe.sv
// Registered decode stage: valid/ready handshake into a two-entry skid buffer
// (or a single register when SKID=0), with flush and async reset.
module core_id_pipe
   import core_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter bit ENABLE_M   = 1'b1,
   parameter bit ENABLE_CSR = 1'b1,
   parameter bit SKID       = 1'b1
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_flush,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [31:0]     i_instr,
   input  logic [XLEN-1:0] i_pc,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_pc,
   output logic [6:0]      o_opcode,
   output logic [2:0]      o_funct3,
   output logic [6:0]      o_funct7,
   output logic [4:0]      o_src1_reg_addr,
   output logic [4:0]      o_src2_reg_addr,
   output logic [4:0]      o_dst_reg_addr,
   output logic            o_src1_reg_en,
   output logic            o_src2_reg_en,
   output logic            o_dst_reg_en,
   output logic [XLEN-1:0] o_imm,
   output logic            o_jal,
   output logic            o_jalr,
   output logic            o_branch,
   output logic            o_alures2reg,
   output logic            o_memory2reg,
   output logic            o_mem_write,
   output logic            o_muldiv,
   output logic            o_csr,
   output logic            o_illegal
);

   dec_t            in_dec;
   logic [XLEN-1:0] in_imm;

   logic            main_vld_q, main_vld_d;
   dec_t            main_dec_q, main_dec_d;
   logic [XLEN-1:0] main_imm_q, main_imm_d;
   logic [XLEN-1:0] main_pc_q,  main_pc_d;
   logic            skid_vld_q, skid_vld_d;
   dec_t            skid_dec_q, skid_dec_d;
   logic [XLEN-1:0] skid_imm_q, skid_imm_d;
   logic [XLEN-1:0] skid_pc_q,  skid_pc_d;
   logic            in_xfer;

   core_id_decode #(
      .XLEN       (XLEN),
      .ENABLE_M   (ENABLE_M),
      .ENABLE_CSR (ENABLE_CSR)
   ) u_decode (
      .i_instr (i_instr),
      .o_dec   (in_dec),
      .o_imm   (in_imm)
   );

   always_comb begin
      if (SKID)
         o_ready = !skid_vld_q;
      else
         o_ready = !i_rst && (!main_vld_q || i_ready);
   end

   always_comb begin
      main_vld_d = main_vld_q;
      main_dec_d = main_dec_q;
      main_imm_d = main_imm_q;
      main_pc_d  = main_pc_q;
      skid_vld_d = skid_vld_q;
      skid_dec_d = skid_dec_q;
      skid_imm_d = skid_imm_q;
      skid_pc_d  = skid_pc_q;
      in_xfer    = i_valid && o_ready;

      if (i_flush) begin
         main_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end else if (main_vld_q && !i_ready) begin
         if (in_xfer && SKID) begin
            skid_vld_d = 1'b1;
            skid_dec_d = in_dec;
            skid_imm_d = in_imm;
            skid_pc_d  = i_pc;
         end
      end else if (skid_vld_q) begin
         // MAIN is empty or draining; SKID holds the older entry, o_ready is low
         main_vld_d = 1'b1;
         main_dec_d = skid_dec_q;
         main_imm_d = skid_imm_q;
         main_pc_d  = skid_pc_q;
         skid_vld_d = 1'b0;
      end else begin
         main_vld_d = in_xfer;
         if (in_xfer) begin
            main_dec_d = in_dec;
            main_imm_d = in_imm;
            main_pc_d  = i_pc;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         main_vld_q <= 1'b0;
         main_dec_q <= '0;
         main_imm_q <= '0;
         main_pc_q  <= '0;
         skid_vld_q <= 1'b0;
         skid_dec_q <= '0;
         skid_imm_q <= '0;
         skid_pc_q  <= '0;
      end else begin
         main_vld_q <= main_vld_d;
         main_dec_q <= main_dec_d;
         main_imm_q <= main_imm_d;
         main_pc_q  <= main_pc_d;
         skid_vld_q <= skid_vld_d;
         skid_dec_q <= skid_dec_d;
         skid_imm_q <= skid_imm_d;
         skid_pc_q  <= skid_pc_d;
      end
   end

   always_comb begin
      o_valid         = main_vld_q;
      o_pc            = main_pc_q;
      o_imm           = main_imm_q;
      o_opcode        = main_dec_q.opcode;
      o_funct3        = main_dec_q.funct3;
      o_funct7        = main_dec_q.funct7;
      o_src1_reg_addr = main_dec_q.src1_addr;
      o_src2_reg_addr = main_dec_q.src2_addr;
      o_dst_reg_addr  = main_dec_q.dst_addr;
      o_src1_reg_en   = main_dec_q.src1_en;
      o_src2_reg_en   = main_dec_q.src2_en;
      o_dst_reg_en    = main_dec_q.dst_en;
      o_jal           = main_dec_q.jal;
      o_jalr          = main_dec_q.jalr;
      o_branch        = main_dec_q.branch;
      o_alures2reg    = main_dec_q.alures2reg;
      o_memory2reg    = main_dec_q.memory2reg;
      o_mem_write     = main_dec_q.mem_write;
      o_muldiv        = main_dec_q.muldiv;
      o_csr           = main_dec_q.csr;
      o_illegal       = main_dec_q.illegal;
   end

endmodule
